// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 8x8 register file: round-robin arbitration between
// the ALU and load writeback requesters, plus a zeroing sweep of R0..R(NREGS-1).
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_REQ,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  output logic              ALU_ACK,
  input  logic              MEM_REQ,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_ACK,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN
);

  // state     | meaning
  // IDLE      | port unused, address/data hold
  // GRANT_ALU | ALU writeback strobed this cycle
  // GRANT_MEM | load writeback strobed this cycle
  // CLEAR     | sweep writes zero to register 'count'
  typedef enum logic [1:0] {IDLE, GRANT_ALU, GRANT_MEM, CLEAR} state_t;

  localparam int CNT_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NREGS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             last_mem, last_mem_nx;
  logic             alu_elig, mem_elig;

  always_comb begin
    state_nx    = IDLE;
    count_nx    = count;
    last_mem_nx = last_mem;
    // A request seen on the edge that ends its own ACK cycle is the one just served.
    alu_elig    = ALU_REQ && !ALU_ACK;
    mem_elig    = MEM_REQ && !MEM_ACK;
    if (state == CLEAR && count != CNT_LAST) begin
      state_nx = CLEAR;
      count_nx = count + 1'b1;
    end else if (state != CLEAR && CLR_REQ) begin
      state_nx = CLEAR;
      count_nx = '0;
    end else if (alu_elig && (!mem_elig || last_mem)) begin
      state_nx    = GRANT_ALU;
      last_mem_nx = 1'b0;
    end else if (mem_elig) begin
      state_nx    = GRANT_MEM;
      last_mem_nx = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      count     <= '0;
      last_mem  <= 1'b1;
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
      ALU_ACK   <= 1'b0;
      MEM_ACK   <= 1'b0;
      CLR_BUSY  <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      last_mem <= last_mem_nx;
      WRITE    <= (state_nx != IDLE);
      ALU_ACK  <= (state_nx == GRANT_ALU);
      MEM_ACK  <= (state_nx == GRANT_MEM);
      CLR_BUSY <= (state_nx == CLEAR);
      case (state_nx)
        GRANT_ALU: begin
          INADDRESS <= ALU_ADDR;
          IN        <= ALU_DATA;
        end
        GRANT_MEM: begin
          INADDRESS <= MEM_ADDR;
          IN        <= MEM_DATA;
        end
        CLEAR: begin
          INADDRESS <= ADDR_W'(count_nx);
          IN        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
